// File: rtl/dcmac_reset_seq_pkg.sv
// Shared definitions for the DCMAC reset sequencer and the register block that reports its status.
package dcmac_pkg;

  localparam int unsigned NumLanes = 4;

  localparam logic [3:0] StateIdle   = 4'd0;
  localparam logic [3:0] StateHold   = 4'd1;
  localparam logic [3:0] StateWaitGt = 4'd2;
  localparam logic [3:0] StateSettle = 4'd3;
  localparam logic [3:0] StateDone   = 4'd4;
  localparam logic [3:0] StateFault  = 4'd5;

  typedef enum logic [3:0] {
    StIdle   = StateIdle,
    StHold   = StateHold,
    StWaitGt = StateWaitGt,
    StSettle = StateSettle,
    StDone   = StateDone,
    StFault  = StateFault
  } seq_state_e;

  // Bit positions of each reset inside the register block's reset word.
  localparam int unsigned RstTxCore   = 0;
  localparam int unsigned RstRxCore   = 1;
  localparam int unsigned RstTxSerdes = 2;
  localparam int unsigned RstRxSerdes = 3;
  localparam int unsigned RstGtTx     = 4;
  localparam int unsigned RstGtRx     = 5;
  localparam int unsigned RstGtAll    = 6;
  localparam int unsigned NumResets   = 7;

  typedef logic [NumResets-1:0] rst_vec_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic rst_vec_t rst_pattern(seq_state_e st);
    rst_vec_t r;
    r = '0;
    case (st)
      StHold: r = '1;
      StSettle: begin
        r[RstRxCore] = 1'b1;
        r[RstTxCore] = 1'b1;
      end
      StDone: r = '0;
      default: begin
        r[RstRxCore]   = 1'b1;
        r[RstTxCore]   = 1'b1;
        r[RstRxSerdes] = 1'b1;
        r[RstTxSerdes] = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcmac_reset_seq_if.sv
// Control/status and reset bundle between the register block, the sequencer and dcmac_helper.
interface dcmac_reset_seq_if;
  import dcmac_pkg::*;

  logic                start;
  logic [NumLanes-1:0] rx_reset_done;
  logic [NumLanes-1:0] tx_reset_done;
  logic                rx_core_reset;
  logic                tx_core_reset;
  logic                rx_serdes_reset;
  logic                tx_serdes_reset;
  logic                gt_reset_all;
  logic                gt_reset_rx_datapath;
  logic                gt_reset_tx_datapath;
  logic                busy;
  logic                done;
  logic                error;
  logic [3:0]          state;

  modport master (
    input  start, rx_reset_done, tx_reset_done,
    output rx_core_reset, tx_core_reset, rx_serdes_reset, tx_serdes_reset,
    output gt_reset_all, gt_reset_rx_datapath, gt_reset_tx_datapath,
    output busy, done, error, state
  );

  modport slave (
    output start, rx_reset_done, tx_reset_done,
    input  rx_core_reset, tx_core_reset, rx_serdes_reset, tx_serdes_reset,
    input  gt_reset_all, gt_reset_rx_datapath, gt_reset_tx_datapath,
    input  busy, done, error, state
  );

endinterface

// File: rtl/dcmac_reset_seq_sync_bits.sv
// Two-flop synchronizer for a vector of independent quasi-static level signals.
module sync_bits #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dcmac_reset_seq.sv
// DCMAC/GT reset sequencer: hold all resets, release GT, wait for lane reset-done,
// release serdes, settle, then release core. Reports busy/done/error and its state.
module dcmac_reset_seq
  import dcmac_pkg::*;
#(
  parameter int unsigned         HOLD_CYCLES    = 256,
  parameter int unsigned         SETTLE_CYCLES  = 1024,
  parameter int unsigned         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [NumLanes-1:0] LANE_MASK      = 4'hF
) (
  input logic               clk,
  input logic               resetn,
  dcmac_reset_seq_if.master bus
);

  localparam int unsigned CntW = $clog2(max3(HOLD_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)) + 1;

  // Counter holds remaining cycles minus one, so a state lasts exactly its load + 1 cycles.
  localparam logic [CntW-1:0] HoldLoad    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYCLES - 1);

  logic [NumLanes-1:0] rx_s;
  logic [NumLanes-1:0] tx_s;
  logic                lanes_ok;

  seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       busy_q;
  rst_vec_t   rst_q;
  logic       cnt_zero;

  sync_bits #(
    .Width (2 * NumLanes)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      ({bus.rx_reset_done, bus.tx_reset_done}),
    .q      ({rx_s, tx_s})
  );

  assign lanes_ok = ((rx_s & tx_s & LANE_MASK) == LANE_MASK);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    error_d = error_q;
    unique case (state_q)
      StIdle, StDone, StFault: begin
        if (bus.start) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StWaitGt;
          cnt_d   = TimeoutLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitGt: begin
        // lanes_ok takes priority over a simultaneous terminal count.
        if (lanes_ok) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else if (cnt_zero) begin
          state_d = StFault;
          cnt_d   = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSettle: begin
        if (!lanes_ok) begin
          state_d = StFault;
          cnt_d   = '0;
          error_d = 1'b1;
        end else if (cnt_zero) begin
          state_d = StDone;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      rst_q   <= rst_pattern(StIdle);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      error_q <= error_d;
      busy_q  <= (state_d == StHold) || (state_d == StWaitGt) || (state_d == StSettle);
      rst_q   <= rst_pattern(state_d);
    end
  end

  assign bus.rx_core_reset        = rst_q[RstRxCore];
  assign bus.tx_core_reset        = rst_q[RstTxCore];
  assign bus.rx_serdes_reset      = rst_q[RstRxSerdes];
  assign bus.tx_serdes_reset      = rst_q[RstTxSerdes];
  assign bus.gt_reset_all         = rst_q[RstGtAll];
  assign bus.gt_reset_rx_datapath = rst_q[RstGtRx];
  assign bus.gt_reset_tx_datapath = rst_q[RstGtTx];
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.error                = error_q;
  assign bus.state                = state_q;

endmodule

// File: tb/tb_dcmac_reset_seq.sv
// Table-driven bench: two sequencers (lane mask F and 3) run side by side against a simple GT
// model that drops reset-done while gt_reset_all is asserted.
module tb_dcmac_reset_seq;

  localparam logic [3:0] SIdle   = 4'd0;
  localparam logic [3:0] SHold   = 4'd1;
  localparam logic [3:0] SWait   = 4'd2;
  localparam logic [3:0] SSettle = 4'd3;
  localparam logic [3:0] SDone   = 4'd4;
  localparam logic [3:0] SFault  = 4'd5;

  typedef struct {
    logic       start;
    logic [3:0] rx;
    logic [3:0] tx;
    logic [3:0] sf;
    logic       df;
    logic       ef;
    logic [3:0] s3;
    logic       d3;
    logic       e3;
  } vec_t;

  vec_t vecs[$];

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] rx_lvl;
  logic [3:0] tx_lvl;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  dcmac_reset_seq_if busf ();
  dcmac_reset_seq_if bus3 ();

  assign busf.start         = start;
  assign busf.rx_reset_done = rx_lvl & {4{~busf.gt_reset_all}};
  assign busf.tx_reset_done = tx_lvl & {4{~busf.gt_reset_all}};
  assign bus3.start         = start;
  assign bus3.rx_reset_done = rx_lvl & {4{~bus3.gt_reset_all}};
  assign bus3.tx_reset_done = tx_lvl & {4{~bus3.gt_reset_all}};

  dcmac_reset_seq #(
    .HOLD_CYCLES    (4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (20),
    .LANE_MASK      (4'hF)
  ) dut_f (
    .clk    (clk),
    .resetn (resetn),
    .bus    (busf)
  );

  dcmac_reset_seq #(
    .HOLD_CYCLES    (4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (20),
    .LANE_MASK      (4'h3)
  ) dut_3 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus3)
  );

  logic [13:0] act_f;
  logic [13:0] act_3;

  // {gt_all, gt_rx, gt_tx, rx_serdes, tx_serdes, rx_core, tx_core, busy, done, error, state}
  assign act_f = {busf.gt_reset_all, busf.gt_reset_rx_datapath, busf.gt_reset_tx_datapath,
                  busf.rx_serdes_reset, busf.tx_serdes_reset, busf.rx_core_reset,
                  busf.tx_core_reset, busf.busy, busf.done, busf.error, busf.state};
  assign act_3 = {bus3.gt_reset_all, bus3.gt_reset_rx_datapath, bus3.gt_reset_tx_datapath,
                  bus3.rx_serdes_reset, bus3.tx_serdes_reset, bus3.rx_core_reset,
                  bus3.tx_core_reset, bus3.busy, bus3.done, bus3.error, bus3.state};

  function automatic logic [13:0] exp_word(logic [3:0] st, logic d, logic e);
    logic [6:0] r;
    logic       b;
    case (st)
      SHold:   r = 7'b111_1111;
      SSettle: r = 7'b000_0011;
      SDone:   r = 7'b000_0000;
      default: r = 7'b000_1111;
    endcase
    b = (st == SHold) || (st == SWait) || (st == SSettle);
    return {r, b, d, e, st};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push(input int n, input logic st, input logic [3:0] rx, input logic [3:0] tx,
                      input logic [3:0] sf, input logic df, input logic ef,
                      input logic [3:0] s3, input logic d3, input logic e3);
    vec_t v;
    v = '{start: st, rx: rx, tx: tx, sf: sf, df: df, ef: ef, s3: s3, d3: d3, e3: e3};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    start  = 1'b0;
    rx_lvl = 4'hF;
    tx_lvl = 4'hF;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #10;
    check("reset_f", act_f, exp_word(SIdle, 1'b0, 1'b0));
    check("reset_3", act_3, exp_word(SIdle, 1'b0, 1'b0));

    // idle while synchronizers fill
    push(3, 0, 4'hF, 4'hF, SIdle, 0, 0, SIdle, 0, 0);
    // nominal sequence
    push(1, 1, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'hF, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(8, 0, 4'hF, 4'hF, SSettle, 0, 0, SSettle, 0, 0);
    push(2, 0, 4'hF, 4'hF, SDone,   1, 0, SDone,   1, 0);
    // lane 3 rx never ready: mask F times out, mask 3 completes
    push(1, 1, 4'h7, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'h7, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'h7, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(8, 0, 4'h7, 4'hF, SWait,   0, 0, SSettle, 0, 0);
    push(9, 0, 4'h7, 4'hF, SWait,   0, 0, SDone,   1, 0);
    push(2, 0, 4'h7, 4'hF, SFault,  0, 1, SDone,   1, 0);
    // restart from FAULT/DONE with extra starts while busy
    push(1, 1, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(1, 1, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(2, 0, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(1, 1, 4'hF, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(1, 0, 4'hF, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(1, 1, 4'hF, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(3, 0, 4'hF, 4'hF, SSettle, 0, 0, SSettle, 0, 0);
    push(1, 1, 4'hF, 4'hF, SSettle, 0, 0, SSettle, 0, 0);
    push(4, 0, 4'hF, 4'hF, SSettle, 0, 0, SSettle, 0, 0);
    push(2, 0, 4'hF, 4'hF, SDone,   1, 0, SDone,   1, 0);
    // tx lane 0 lost during SETTLE; start on the FAULT-entry edge is ignored
    push(1, 1, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'hF, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(2, 0, 4'hF, 4'hF, SSettle, 0, 0, SSettle, 0, 0);
    push(2, 0, 4'hF, 4'hE, SSettle, 0, 0, SSettle, 0, 0);
    push(1, 1, 4'hF, 4'hE, SFault,  0, 1, SFault,  0, 1);
    push(2, 0, 4'hF, 4'hE, SFault,  0, 1, SFault,  0, 1);
    // lanes_ok arrives on the terminal-count cycle: SETTLE wins over FAULT
    push(1, 1, 4'h7, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'h7, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'h7, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(8, 0, 4'h7, 4'hF, SWait,   0, 0, SSettle, 0, 0);
    push(7, 0, 4'h7, 4'hF, SWait,   0, 0, SDone,   1, 0);
    push(2, 0, 4'hF, 4'hF, SWait,   0, 0, SDone,   1, 0);
    push(8, 0, 4'hF, 4'hF, SSettle, 0, 0, SDone,   1, 0);
    push(1, 0, 4'hF, 4'hF, SDone,   1, 0, SDone,   1, 0);
    // run into SETTLE ahead of the asynchronous reset
    push(1, 1, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'hF, 4'hF, SHold,   0, 0, SHold,   0, 0);
    push(3, 0, 4'hF, 4'hF, SWait,   0, 0, SWait,   0, 0);
    push(3, 0, 4'hF, 4'hF, SSettle, 0, 0, SSettle, 0, 0);

    #5 resetn = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      start  = vecs[i].start;
      rx_lvl = vecs[i].rx;
      tx_lvl = vecs[i].tx;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_f", i), act_f, exp_word(vecs[i].sf, vecs[i].df, vecs[i].ef));
      check($sformatf("vec%0d_3", i), act_3, exp_word(vecs[i].s3, vecs[i].d3, vecs[i].e3));
    end
    start = 1'b0;

    // asynchronous reset mid-SETTLE, away from any clock edge
    #2 resetn = 1'b0;
    #1;
    check("async_rst_f", act_f, exp_word(SIdle, 1'b0, 1'b0));
    check("async_rst_3", act_3, exp_word(SIdle, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_resume_f", act_f, exp_word(SIdle, 1'b0, 1'b0));
    check("no_resume_3", act_3, exp_word(SIdle, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
